// File: rtl/handshake_unit.sv
// Peripheral side of the HEI handshake: synchronises and debounces the push-button into a
// clean Handshake level, and captures the slide switches on every accepted press.
module handshake_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SW_WIDTH        = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Button,
  input  logic [SW_WIDTH-1:0] Switches,
  input  logic                PCHold,
  output logic                Handshake,
  output logic [SW_WIDTH-1:0] SwData,
  output logic [7:0]          PressCount,
  output logic                Waiting
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  btn_meta, btn_s;
  logic [SW_WIDTH-1:0]   sw_meta, sw_s;
  logic                  press_accept, release_accept;

  // The count for the current sampled cycle completes the debounce window. With a window of
  // one cycle the first stable sample already qualifies, so the wait state is bypassed.
  always_comb begin
    press_accept   = 1'b0;
    release_accept = 1'b0;
    unique case (state_q)
      StReleased:    press_accept   = btn_s && (CNT_LAST == '0);
      StPressWait:   press_accept   = btn_s && (cnt_q == CNT_LAST);
      StPressed:     release_accept = !btn_s && (CNT_LAST == '0);
      StReleaseWait: release_accept = !btn_s && (cnt_q == CNT_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_meta   <= 1'b0;
      btn_s      <= 1'b0;
      sw_meta    <= '0;
      sw_s       <= '0;
      state_q    <= StReleased;
      cnt_q      <= '0;
      Handshake  <= 1'b0;
      SwData     <= '0;
      PressCount <= 8'd0;
      Waiting    <= 1'b0;
    end else begin
      btn_meta <= Button;
      btn_s    <= btn_meta;
      sw_meta  <= Switches;
      sw_s     <= sw_meta;
      Waiting  <= PCHold;

      if (press_accept) begin
        state_q    <= StPressed;
        cnt_q      <= '0;
        Handshake  <= 1'b1;
        SwData     <= sw_s;
        PressCount <= PressCount + 8'd1;
      end else if (release_accept) begin
        state_q   <= StReleased;
        cnt_q     <= '0;
        Handshake <= 1'b0;
      end else begin
        unique case (state_q)
          StReleased: begin
            if (btn_s) begin
              state_q <= StPressWait;
              cnt_q   <= CNT_ONE;
            end
          end
          StPressWait: begin
            if (!btn_s) begin
              state_q <= StReleased;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          StPressed: begin
            if (!btn_s) begin
              state_q <= StReleaseWait;
              cnt_q   <= CNT_ONE;
            end
          end
          StReleaseWait: begin
            // A bounce back to pressed returns silently: no new capture or count.
            if (btn_s) begin
              state_q <= StPressed;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_handshake_unit.sv
// Bench for handshake_unit: directed vector table, hand-written multi-cycle sequences and a
// randomized phase, all cross-checked against a run-length debounce reference model.
module tb_handshake_unit;

  localparam int unsigned DEB = 4;

  logic       Clock;
  logic       Reset;
  logic       Button;
  logic [7:0] Switches;
  logic       PCHold;
  logic       Handshake;
  logic [7:0] SwData;
  logic [7:0] PressCount;
  logic       Waiting;

  handshake_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH       (8)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Button    (Button),
    .Switches  (Switches),
    .PCHold    (PCHold),
    .Handshake (Handshake),
    .SwData    (SwData),
    .PressCount(PressCount),
    .Waiting   (Waiting)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: accepted level flips once the synchronised button has disagreed with it
  // for DEB consecutive samples.
  logic       m_b1 = 1'b0, m_b2 = 1'b0;
  logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00;
  logic       m_level = 1'b0;
  int         m_run = 0;
  logic [7:0] m_sw = 8'h00;
  int         m_pc = 0;
  logic       m_wait = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (Reset) begin
      m_b1 = 1'b0; m_b2 = 1'b0; m_s1 = 8'h00; m_s2 = 8'h00;
      m_level = 1'b0; m_run = 0; m_sw = 8'h00; m_pc = 0; m_wait = 1'b0;
    end else begin
      if (m_b2 != m_level) begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_level = m_b2;
          m_run   = 0;
          if (m_b2) begin
            m_sw = m_s2;
            m_pc = (m_pc + 1) % 256;
          end
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1; m_b1 = Button;
      m_s2 = m_s1; m_s1 = Switches;
      m_wait = PCHold;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    check("model_hs",   32'(Handshake),  32'(m_level));
    check("model_sw",   32'(SwData),     32'(m_sw));
    check("model_pc",   32'(PressCount), m_pc);
    check("model_wait", 32'(Waiting),    32'(m_wait));
  endtask

  task automatic run(input logic rst, input logic btn, input logic [7:0] sw, input logic hold,
                     input int n);
    Reset = rst; Button = btn; Switches = sw; PCHold = hold;
    repeat (n) tick();
  endtask

  task automatic expect_out(input string name, input logic hs, input logic [7:0] swd,
                            input logic [7:0] pc, input logic wt);
    check({name, "_hs"},   32'(Handshake),  32'(hs));
    check({name, "_sw"},   32'(SwData),     32'(swd));
    check({name, "_pc"},   32'(PressCount), 32'(pc));
    check({name, "_wait"}, 32'(Waiting),    32'(wt));
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic       btn;
    logic [7:0] sw;
    logic       hold;
    int         cycles;
    logic       hs;
    logic [7:0] swd;
    logic [7:0] pc;
    logic       wt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic rst, input logic btn,
                              input logic [7:0] sw, input logic hold, input int cycles,
                              input logic hs, input logic [7:0] swd, input logic [7:0] pc,
                              input logic wt);
    vec_t v;
    v.name = name; v.rst = rst; v.btn = btn; v.sw = sw; v.hold = hold; v.cycles = cycles;
    v.hs = hs; v.swd = swd; v.pc = pc; v.wt = wt;
    vecs.push_back(v);
  endfunction

  initial begin
    Reset = 1'b1; Button = 1'b0; Switches = 8'h00; PCHold = 1'b0;

    // Press latency is 2 sync + DEB debounce edges = 6 with DEB=4.
    add("reset",       1, 0, 8'h00, 0, 3, 0, 8'h00, 8'd0, 0);
    add("idle_sw",     0, 0, 8'hA5, 0, 3, 0, 8'h00, 8'd0, 0);
    add("press_pre",   0, 1, 8'hA5, 0, 5, 0, 8'h00, 8'd0, 0);
    add("press_edge6", 0, 1, 8'hA5, 0, 1, 1, 8'hA5, 8'd1, 0);
    add("sw_change",   0, 1, 8'h3C, 0, 4, 1, 8'hA5, 8'd1, 0);
    add("rel_pre",     0, 0, 8'h3C, 0, 5, 1, 8'hA5, 8'd1, 0);
    add("rel_edge6",   0, 0, 8'h3C, 0, 1, 0, 8'hA5, 8'd1, 0);
    add("idle",        0, 0, 8'h3C, 0, 3, 0, 8'hA5, 8'd1, 0);
    for (int k = 0; k < 5; k++) begin
      add("bounce_hi", 0, 1, 8'h3C, 0, 3, 0, 8'hA5, 8'd1, 0);
      add("bounce_lo", 0, 0, 8'h3C, 0, 2, 0, 8'hA5, 8'd1, 0);
    end
    add("bounce_end",  0, 0, 8'h3C, 0, 4, 0, 8'hA5, 8'd1, 0);
    add("press2",      0, 1, 8'h5A, 0, 6, 1, 8'h5A, 8'd2, 0);
    add("drop",        0, 0, 8'h5A, 0, 2, 1, 8'h5A, 8'd2, 0);
    add("back",        0, 1, 8'h5A, 0, 4, 1, 8'h5A, 8'd2, 0);
    add("rel2_pre",    0, 0, 8'h5A, 0, 5, 1, 8'h5A, 8'd2, 0);
    add("rel2_edge6",  0, 0, 8'h5A, 0, 1, 0, 8'h5A, 8'd2, 0);
    add("hold_on",     0, 0, 8'h5A, 1, 1, 0, 8'h5A, 8'd2, 1);
    add("hold_off",    0, 0, 8'h5A, 0, 1, 0, 8'h5A, 8'd2, 0);

    foreach (vecs[i]) begin
      run(vecs[i].rst, vecs[i].btn, vecs[i].sw, vecs[i].hold, vecs[i].cycles);
      expect_out(vecs[i].name, vecs[i].hs, vecs[i].swd, vecs[i].pc, vecs[i].wt);
    end

    // Reset during PRESS_WAIT and during PRESSED with the button held throughout.
    run(1, 0, 8'h00, 0, 2);
    run(0, 1, 8'hC3, 0, 4);
    expect_out("pw_mid", 0, 8'h00, 8'd0, 0);
    run(1, 1, 8'hC3, 0, 1);
    expect_out("rst_in_pw", 0, 8'h00, 8'd0, 0);
    run(0, 1, 8'hC3, 0, 5);
    expect_out("post_rst_pre", 0, 8'h00, 8'd0, 0);
    run(0, 1, 8'hC3, 0, 1);
    expect_out("post_rst_press", 1, 8'hC3, 8'd1, 0);
    run(1, 1, 8'hC3, 0, 1);
    expect_out("rst_in_pressed", 0, 8'h00, 8'd0, 0);
    run(0, 1, 8'hC3, 0, 6);
    expect_out("repress", 1, 8'hC3, 8'd1, 0);

    // 256 clean presses from reset wrap the counter back to zero.
    run(1, 0, 8'h00, 0, 1);
    run(0, 0, 8'h00, 0, 3);
    for (int i = 1; i <= 256; i++) begin
      run(0, 1, 8'(i), 0, 7);
      if (i == 255) expect_out("press255", 1, 8'hFF, 8'd255, 0);
      run(0, 0, 8'(i), 0, 7);
    end
    expect_out("wrap", 0, 8'h00, 8'd0, 0);
    run(0, 0, 8'h00, 1, 1);
    expect_out("waiting", 0, 8'h00, 8'd0, 1);

    // Randomized phase: random hold lengths straddle the debounce window.
    run(1, 0, 8'h00, 0, 1);
    begin
      logic [7:0] sw;
      sw = 8'h00;
      for (int i = 0; i < 400; i++) begin
        logic rst, btn, hold;
        int   n;
        if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
        btn  = 1'($urandom);
        hold = 1'($urandom);
        rst  = ($urandom_range(0, 63) == 0);
        n    = rst ? 1 : int'($urandom_range(1, 7));
        run(rst, btn, sw, hold, n);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
